ldpc_llr_loader: RTL

LDPC_LLR_LOADER -- requirements
Module: ldpc_llr_loader

---
 rtl/ldpc_llr_loader_if.sv | 14 +
 rtl/ldpc_llr_loader.sv | 105 ++++++++++
 2 files changed

// File: rtl/ldpc_llr_loader_if.sv
// Input beat stream into the LLR loader: valid/ready handshake with a P-LLR beat
// and an end-of-frame marker.
interface ldpc_llr_loader_if #(
  parameter int P    = 8,
  parameter int in_w = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [P*in_w-1:0] in_llr;
  logic              in_last;

  modport master (output in_valid, output in_llr, output in_last, input in_ready);
  modport slave  (input in_valid, input in_llr, input in_last, output in_ready);
endinterface

// File: rtl/ldpc_llr_loader.sv
// Collects a frame of saturated LLRs from the input beat stream, then hands the
// assembled frame to the decoder with a restart pulse and holds it while decoding.
module ldpc_llr_loader #(
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int data_w = 6,
  parameter int in_w   = 8,
  parameter int P      = 8,
  parameter int SAT    = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  ldpc_llr_loader_if.slave        in_if,
  output logic [R*D*data_w-1:0]   l,
  output logic                    dec_rst,
  output logic                    dec_en,
  input  logic                    dec_term,
  output logic                    frame_err,
  output logic [15:0]             frame_cnt
);

  localparam int NLLR = R * D;
  localparam int NB   = NLLR / P;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW   = (NLLR > 1) ? $clog2(NLLR) : 1;

  typedef enum logic [1:0] {FILL, START, DECODE} state_t;

  state_t            state;
  logic [BW-1:0]     beat_cnt;
  logic              first_dec;
  logic [data_w-1:0] mem [NLLR];
  logic              accept;
  logic              last_slot;

  assign accept    = in_if.in_valid & in_if.in_ready;
  assign last_slot = (beat_cnt == BW'(NB - 1));

  function automatic logic [data_w-1:0] sat_llr(input logic signed [in_w-1:0] x);
    int xi;
    xi = int'(x);
    if (xi > SAT)       return data_w'(SAT);
    else if (xi < -SAT) return data_w'(-SAT);
    else                return data_w'(xi);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= FILL;
      beat_cnt       <= '0;
      first_dec      <= 1'b0;
      in_if.in_ready <= 1'b1;
      dec_rst        <= 1'b0;
      dec_en         <= 1'b0;
      frame_err      <= 1'b0;
      frame_cnt      <= '0;
      for (int unsigned i = 0; i < NLLR; i++) mem[i] <= '0;
    end else begin
      dec_rst   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            for (int unsigned k = 0; k < P; k++)
              mem[AW'(int'(beat_cnt) * P + int'(k))] <=
                sat_llr(in_if.in_llr[(P - int'(k))*in_w-1 -: in_w]);
            if (in_if.in_last && last_slot) begin
              beat_cnt       <= '0;
              state          <= START;
              in_if.in_ready <= 1'b0;
              dec_rst        <= 1'b1;
            end else if (in_if.in_last || last_slot) begin
              beat_cnt  <= '0;
              frame_err <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        START: begin
          state     <= DECODE;
          dec_en    <= 1'b1;
          first_dec <= 1'b1;
          frame_cnt <= frame_cnt + 1'b1;
        end
        DECODE: begin
          // first_dec marks the cycle right after the restart pulse, where
          // dec_term may still be left over from the previous frame.
          first_dec <= 1'b0;
          if (dec_term && !first_dec) begin
            state          <= FILL;
            dec_en         <= 1'b0;
            in_if.in_ready <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar i = 0; i < NLLR; i++) begin : g_l
    assign l[(NLLR-i)*data_w-1 -: data_w] = mem[i];
  end

endmodule
